program_loader: RTL and testbench

Upstream front-end for the pipelined CPU: accepts a byte stream over a valid/ready handshake and writes it sequentially into the CPU's byte-wide program memory through the memory's write port (write enable, address, data). The CPU is held in reset for the whole load and for a fixed flush window afterwards, so the pipeline starts clean from address 0. A new load can be triggered at run time, which re-halts the CPU.

---
 rtl/program_loader.sv | 132 +++++++++++++
 tb/tb_program_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams bytes into the CPU program memory and holds the CPU in reset while
// loading and for a short flush window afterwards.
module program_loader #(
  parameter int ADD_WIDTH    = 7,
  parameter int DATA_WIDTH   = 8,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  pm_wr_en,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] pm_data,
  output logic                  cpu_rst,
  output logic                  full,
  output logic [ADD_WIDTH:0]    byte_count,
  output logic [1:0]            state_dbg
);

  // Handshake: a byte transfers on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready is registered and high only in LOAD.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
  localparam logic [FW-1:0]      FLUSH_INIT = FW'(FLUSH_CYCLES - 1);
  localparam logic [ADD_WIDTH:0] COUNT_MAX  = {1'b1, {ADD_WIDTH{1'b0}}};

  state_t                 state_q;
  state_t                 state_d;
  logic [ADD_WIDTH-1:0]   addr_q;
  logic [FW-1:0]          flush_q;
  logic                   load_en_q;
  logic                   accept;
  logic                   last_addr;
  logic                   cpu_rst_d;
  logic                   byte_ready_d;

  assign accept    = byte_valid & byte_ready;
  assign last_addr = (addr_q == {ADD_WIDTH{1'b1}});
  assign state_dbg = state_q;

  // State register plus the registered datapath it controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cpu_rst    <= 1'b1;
      byte_ready <= 1'b0;
      pm_wr_en   <= 1'b0;
      pm_addr    <= '0;
      pm_data    <= '0;
      full       <= 1'b0;
      byte_count <= '0;
      addr_q     <= '0;
      flush_q    <= '0;
      load_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_rst    <= cpu_rst_d;
      byte_ready <= byte_ready_d;
      load_en_q  <= load_en;
      pm_wr_en   <= 1'b0;

      if (state_d == LOAD && state_q != LOAD) begin
        addr_q     <= '0;
        byte_count <= '0;
        full       <= 1'b0;
      end

      if (state_d == FLUSH && state_q != FLUSH) begin
        flush_q <= FLUSH_INIT;
      end else if (state_q == FLUSH && flush_q != '0) begin
        flush_q <= flush_q - 1'b1;
      end

      // The address counter may wrap after the last byte, but LOAD is left
      // on that same edge so the wrapped value is never used.
      if (state_q == LOAD && accept) begin
        pm_wr_en <= 1'b1;
        pm_addr  <= addr_q;
        pm_data  <= byte_in;
        addr_q   <= addr_q + 1'b1;
        if (byte_count != COUNT_MAX) begin
          byte_count <= byte_count + 1'b1;
        end
        if (last_addr) begin
          full <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load_en ? LOAD : FLUSH;
      LOAD: begin
        if (accept && last_addr) begin
          state_d = FLUSH;
        end else if (!load_en) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_q == '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (load_en && !load_en_q) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they switch with the state.
  always_comb begin
    cpu_rst_d    = (state_d != RUN);
    byte_ready_d = (state_d == LOAD);
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset/flush timing, streaming, gaps,
// full-memory load, run-time reload and reset during a load.
module tb_program_loader;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [DW-1:0] byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          pm_wr_en;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] pm_data;
  logic          cpu_rst;
  logic          full;
  logic [AW:0]   byte_count;
  logic [1:0]    state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [AW+DW-1:0] exp_q[$];

  program_loader #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pm_wr_en(pm_wr_en),
    .pm_addr(pm_addr), .pm_data(pm_data), .cpu_rst(cpu_rst), .full(full),
    .byte_count(byte_count), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change right after a sampling point at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (cpu_rst !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    tests_run++;
    if (cpu_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_wait_run: cpu_rst=%b required 0 within 50 cycles", name, cpu_rst);
    end
  endtask

  task automatic test_reset();
    logic wr_seen = 1'b0;
    rst = 1'b1; load_en = 1'b0; byte_valid = 1'b0; byte_in = '0;
    repeat (3) tick();
    tests_run++;
    if ({cpu_rst, byte_ready, pm_wr_en, full} !== 4'b1000 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rst/rdy/wr/full=%b%b%b%b state=%0d required 1000 state 0",
               cpu_rst, byte_ready, pm_wr_en, full, state_dbg);
    end
    tests_run++;
    if (pm_addr !== '0 || pm_data !== '0 || byte_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%0h data=%0h count=%0d required 0 0 0",
               pm_addr, pm_data, byte_count);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      wr_seen |= pm_wr_en;
      tests_run++;
      if (i < 5 && (cpu_rst !== 1'b1 || state_dbg !== 2'd2)) begin
        tests_failed++;
        $display("FAIL reset_flush_%0d: cpu_rst=%b state=%0d required 1 state 2", i, cpu_rst, state_dbg);
      end else if (i == 5 && (cpu_rst !== 1'b0 || state_dbg !== 2'd3)) begin
        tests_failed++;
        $display("FAIL reset_release: cpu_rst=%b state=%0d required 0 state 3", cpu_rst, state_dbg);
      end
    end
    tests_run++;
    if (wr_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_write: pm_wr_en seen=%b required 0", wr_seen);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] pat [4] = '{8'h13, 8'h00, 8'h50, 8'h00};
    load_en = 1'b1;
    tick();
    tests_run++;
    if ({cpu_rst, byte_ready, full} !== 3'b110 || byte_count !== '0) begin
      tests_failed++;
      $display("FAIL stream_enter: rst/rdy/full=%b%b%b count=%0d required 110 count 0",
               cpu_rst, byte_ready, full, byte_count);
    end
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; byte_in = pat[i];
      tick();
      tests_run++;
      if (pm_wr_en !== 1'b1 || pm_addr !== AW'(i) || pm_data !== pat[i]) begin
        tests_failed++;
        $display("FAIL stream_write_%0d: wr=%b addr=%0d data=%02h required 1 %0d %02h",
                 i, pm_wr_en, pm_addr, pm_data, i, pat[i]);
      end
    end
    byte_valid = 1'b0; load_en = 1'b0;
    tick();
    tests_run++;
    if (byte_count !== 8'd4 || pm_wr_en !== 1'b0 || byte_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end: count=%0d wr=%b rdy=%b required 4 0 0", byte_count, pm_wr_en, byte_ready);
    end
    for (int j = 1; j <= FC; j++) begin
      tick();
      tests_run++;
      if (cpu_rst !== (j < FC)) begin
        tests_failed++;
        $display("FAIL stream_flush_%0d: cpu_rst=%b required %b", j, cpu_rst, (j < FC));
      end
    end
  endtask

  task automatic test_valid_gaps();
    load_en = 1'b1;
    tick();
    byte_valid = 1'b1; byte_in = 8'hA1;
    tick();
    tests_run++;
    if (pm_wr_en !== 1'b1 || pm_addr !== 7'd0 || pm_data !== 8'hA1) begin
      tests_failed++;
      $display("FAIL gaps_first: wr=%b addr=%0d data=%02h required 1 0 a1", pm_wr_en, pm_addr, pm_data);
    end
    byte_valid = 1'b0; byte_in = 8'hB2;
    tick();
    tests_run++;
    if (pm_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL gaps_hole: wr=%b required 0", pm_wr_en);
    end
    byte_valid = 1'b1; byte_in = 8'hC3;
    tick();
    tests_run++;
    if (pm_wr_en !== 1'b1 || pm_addr !== 7'd1 || pm_data !== 8'hC3) begin
      tests_failed++;
      $display("FAIL gaps_second: wr=%b addr=%0d data=%02h required 1 1 c3", pm_wr_en, pm_addr, pm_data);
    end
    byte_valid = 1'b0; load_en = 1'b0;
    tick();
    tests_run++;
    if (byte_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL gaps_count: count=%0d required 2", byte_count);
    end
    wait_run("gaps");
  endtask

  task automatic test_full();
    logic [AW+DW-1:0] exp;
    logic wr_seen = 1'b0;
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 128; i++) begin
      byte_valid = 1'b1; byte_in = DW'(i) ^ 8'h5A;
      exp_q.push_back({AW'(i), DW'(i) ^ 8'h5A});
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (pm_wr_en !== 1'b1 || {pm_addr, pm_data} !== exp) begin
        tests_failed++;
        $display("FAIL full_write_%0d: wr=%b addr=%0d data=%02h required 1 %0d %02h",
                 i, pm_wr_en, pm_addr, pm_data, exp[AW+DW-1:DW], exp[DW-1:0]);
      end
    end
    byte_in = 8'hFF;
    tests_run++;
    if (full !== 1'b1 || byte_count !== 8'd128 || byte_ready !== 1'b0 || state_dbg !== 2'd2) begin
      tests_failed++;
      $display("FAIL full_end: full=%b count=%0d rdy=%b state=%0d required 1 128 0 2",
               full, byte_count, byte_ready, state_dbg);
    end
    for (int j = 1; j <= FC; j++) begin
      tick();
      wr_seen |= pm_wr_en;
      tests_run++;
      if (cpu_rst !== (j < FC)) begin
        tests_failed++;
        $display("FAIL full_flush_%0d: cpu_rst=%b required %b", j, cpu_rst, (j < FC));
      end
    end
    repeat (6) begin
      tick();
      wr_seen |= pm_wr_en;
    end
    tests_run++;
    if (wr_seen !== 1'b0 || cpu_rst !== 1'b0 || byte_ready !== 1'b0 || byte_count !== 8'd128) begin
      tests_failed++;
      $display("FAIL full_no_restart: wr_seen=%b cpu_rst=%b rdy=%b count=%0d required 0 0 0 128",
               wr_seen, cpu_rst, byte_ready, byte_count);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reload_in_run();
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
    tests_run++;
    if ({cpu_rst, byte_ready, full} !== 3'b110 || byte_count !== '0) begin
      tests_failed++;
      $display("FAIL reload_enter: rst/rdy/full=%b%b%b count=%0d required 110 count 0",
               cpu_rst, byte_ready, full, byte_count);
    end
    byte_valid = 1'b1; byte_in = 8'h77;
    tick();
    tests_run++;
    if (pm_wr_en !== 1'b1 || pm_addr !== 7'd0 || pm_data !== 8'h77) begin
      tests_failed++;
      $display("FAIL reload_write: wr=%b addr=%0d data=%02h required 1 0 77", pm_wr_en, pm_addr, pm_data);
    end
    byte_valid = 1'b0; load_en = 1'b0;
    tick();
    wait_run("reload");
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] pat [3] = '{8'h11, 8'h22, 8'h33};
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1; byte_in = pat[i];
      tick();
      tests_run++;
      if (pm_wr_en !== 1'b1 || pm_addr !== AW'(i) || pm_data !== pat[i]) begin
        tests_failed++;
        $display("FAIL midrst_write_%0d: wr=%b addr=%0d data=%02h required 1 %0d %02h",
                 i, pm_wr_en, pm_addr, pm_data, i, pat[i]);
      end
    end
    rst = 1'b1; byte_in = 8'h44;
    tick();
    tests_run++;
    if ({cpu_rst, byte_ready, pm_wr_en, full} !== 4'b1000 || state_dbg !== 2'd0 ||
        pm_addr !== '0 || pm_data !== '0 || byte_count !== '0) begin
      tests_failed++;
      $display("FAIL midrst_values: rst/rdy/wr/full=%b%b%b%b state=%0d addr=%0d data=%02h count=%0d required 1000 0 0 00 0",
               cpu_rst, byte_ready, pm_wr_en, full, state_dbg, pm_addr, pm_data, byte_count);
    end
    rst = 1'b0; byte_valid = 1'b0;
    tick();
    byte_valid = 1'b1; byte_in = 8'h99;
    tick();
    tests_run++;
    if (pm_wr_en !== 1'b1 || pm_addr !== 7'd0 || pm_data !== 8'h99) begin
      tests_failed++;
      $display("FAIL midrst_restart: wr=%b addr=%0d data=%02h required 1 0 99", pm_wr_en, pm_addr, pm_data);
    end
    byte_valid = 1'b0; load_en = 1'b0;
    tick();
    wait_run("midrst");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_valid_gaps();
    test_full();
    test_reload_in_run();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
